// File: rtl/seven_seg_scanner_if.sv
// Display bus between the clock datapath and the digit scanner.
// Master drives BCD digits and masks; slave drives an/seg/dp (active-low).
interface seven_seg_scanner_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_mask;
  logic [3:0] blink_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output digit0,
    output digit1,
    output digit2,
    output digit3,
    output dp_mask,
    output blink_mask,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  digit0,
    input  digit1,
    input  digit2,
    input  digit3,
    input  dp_mask,
    input  blink_mask,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed seven-segment driver with guard slot and blinking.
// Ports: clk, rst (sync, high); bus.slave carries digits/masks in, an/seg/dp out.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic               clk,
  input logic               rst,
  seven_seg_scanner_if.slave bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          r_wrap;
  logic          b_wrap;
  logic [3:0]    cur_digit;
  logic          blank;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] decode(
    input logic [3:0] v
  );
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign r_wrap = (refresh_cnt == R_LAST);
  assign b_wrap = (blink_cnt == B_LAST);

  always_comb begin
    cur_digit = bus.digit0;
    unique case (idx)
      2'd0: cur_digit = bus.digit0;
      2'd1: cur_digit = bus.digit1;
      2'd2: cur_digit = bus.digit2;
      2'd3: cur_digit = bus.digit3;
    endcase
  end

  // Slot 0 is the dark guard cycle that separates two lit digits.
  always_comb begin
    blank = (refresh_cnt == '0) ||
            (bus.blink_mask[idx] && blink_phase);
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = decode(cur_digit);
      dp_d  = ~bus.dp_mask[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      bus.an      <= AN_OFF;
      bus.seg     <= SEG_OFF;
      bus.dp      <= 1'b1;
    end else begin
      refresh_cnt <= r_wrap ? '0 : refresh_cnt + 1'b1;
      idx         <= r_wrap ? idx + 2'd1 : idx;
      blink_cnt   <= b_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= b_wrap ? ~blink_phase : blink_phase;
      bus.an      <= an_d;
      bus.seg     <= seg_d;
      bus.dp      <= dp_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized scoreboard bench for seven_seg_scanner.
// Model derives slot/digit/phase from the edge count since reset.
module tb_seven_seg_scanner;

  localparam int RD = 4;
  localparam int BD = 8;
  localparam logic [11:0] GUARD = {4'b1111, 7'b1111111, 1'b1};

  logic clk = 1'b0;
  logic rst;

  seven_seg_scanner_if bus ();

  seven_seg_scanner #(
    .REFRESH_DIV(RD),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000;
    seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001;
    seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010;
    seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
  end

  logic [11:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int k = 0;

  // Reference: edge k after reset lights digit (k/RD)%4 unless
  // k%RD==0 (guard) or that digit blinks in phase (k/BD)%2==1.
  always @(posedge clk) begin
    int pos;
    int d;
    int ph;
    logic [3:0] v;
    logic [3:0] an_e;
    if (rst) begin
      k = 0;
      exp_q.push_back(GUARD);
    end else begin
      pos = k % RD;
      d = (k / RD) % 4;
      ph = (k / BD) % 2;
      case (d)
        0: v = bus.digit0;
        1: v = bus.digit1;
        2: v = bus.digit2;
        default: v = bus.digit3;
      endcase
      if (pos == 0 || (bus.blink_mask[d] && ph == 1)) begin
        exp_q.push_back(GUARD);
      end else begin
        an_e = 4'b1111;
        an_e[d] = 1'b0;
        exp_q.push_back({an_e, seg_tab[v], ~bus.dp_mask[d]});
      end
      k++;
    end
  end

  logic [3:0] prev_an = 4'b1111;

  always @(posedge clk) begin
    logic [11:0] e;
    logic [11:0] a;
    #1;
    a = {bus.an, bus.seg, bus.dp};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: got an=%b seg=%b dp=%b, expected an entry",
               bus.an, bus.seg, bus.dp);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL pins t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 $time, a[11:8], a[7:1], a[0], e[11:8], e[7:1], e[0]);
      end
    end
    checks++;
    if ($countones(~bus.an) > 1 ||
        (prev_an != 4'b1111 && bus.an != 4'b1111 && bus.an != prev_an)) begin
      failures++;
      $display("FAIL anode_guard t=%0t: got an=%b after %b, expected one low max with guard between",
               $time, bus.an, prev_an);
    end
    prev_an = bus.an;
  end

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    bus.digit3 = d3;
    bus.digit2 = d2;
    bus.digit1 = d1;
    bus.digit0 = d0;
  endtask

  initial begin
    int i;
    rst = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    bus.dp_mask = 4'b0000;
    bus.blink_mask = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * RD * 2) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      bus.digit0 = 4'(v);
      repeat (4 * RD) @(negedge clk);
    end

    bus.dp_mask = 4'b0100;
    repeat (4 * RD * 2) @(negedge clk);
    bus.dp_mask = 4'b0000;

    set_digits(4'd8, 4'd8, 4'd8, 4'd8);
    bus.blink_mask = 4'b0001;
    repeat (4 * BD) @(negedge clk);
    bus.blink_mask = 4'b1111;
    repeat (4 * BD) @(negedge clk);
    bus.blink_mask = 4'b0000;

    i = 0;
    while (i < 64 && bus.an != 4'b1011) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (bus.an != 4'b1011) begin
      failures++;
      $display("FAIL wait_digit2: got an=%b, expected 1011 within 64 cycles",
               bus.an);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4 * RD * 2) @(negedge clk);

    for (int c = 0; c < 600; c++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (c % 16 == 0) begin
        bus.dp_mask = 4'($urandom_range(0, 15));
        bus.blink_mask = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed 4-digit seven-segment display driver for the alarm clock. It reads the BCD digit values produced by the clock's up/down modulo counters and drives the shared active-low segment bus and per-digit anodes. It scans one digit at a time with an inter-digit ghosting guard, and supports per-digit blinking for the time-set and alarm-set modes. It sits between the counter datapath and the board's display pins.

## Interface
- REFRESH_DIV, 50000, clock cycles per digit slot including the guard cycle; must be ≥ 2
- BLINK_DIV, 25000000, clock cycles per blink half-period; must be ≥ 1
- clk  input  1  system clock; the only clock
- rst  input  1  synchronous, active-high reset
- digit0  input  4  BCD value for the rightmost digit (minutes units)
- digit1  input  4  BCD value for digit 1
- digit2  input  4  BCD value for digit 2
- digit3  input  4  BCD value for the leftmost digit (hours tens)
- dp_mask  input  4  bit i = 1 lights the decimal point of digit i
- blink_mask  input  4  bit i = 1 makes digit i blink
- an  output  4  anode enables, active-low; an[i] selects digit i
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  output  1  decimal point, active-low

## Operation
- State: refresh_cnt (0..REFRESH_DIV-1), idx (2 bits, 0..3), blink_cnt (0..BLINK_DIV-1), blink_phase (1 bit).
- refresh_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0, wrapping modulo 4.
- blink_cnt increments every cycle. At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- All outputs are registered. Each edge loads an/seg/dp from the pre-edge state and the current inputs:
  - Guard slot (refresh_cnt == 0): an=1111, seg=1111111, dp=1.
  - Blink-off (blink_mask[idx]=1 and blink_phase=1): same all-off value as the guard slot.
  - Otherwise: an = ~(1<<idx), seg = decode(digit[idx]), dp = ~dp_mask[idx].
- Decode table, gfedcba, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 1111111 (blank)
- Inputs are not latched. A digit change mid-slot appears on seg at the next edge. The guard cycle prevents ghosting only across digit switches.
- Reset clears all state and drives the outputs to the guard value:
  - refresh_cnt=0, idx=0, blink_cnt=0, blink_phase=0
  - an=1111, seg=1111111, dp=1
- Reset mid-scan takes effect at the next edge, with no partial frame retained.

## Timing
- Output latency: 1 cycle from state/input to pins.
- After rst falls, edge 1 outputs the guard value (refresh_cnt was 0). Edge 2 shows digit 0 (an=1110).
- Each digit is lit for REFRESH_DIV-1 cycles, followed by 1 blank cycle.
- Frame period: 4·REFRESH_DIV cycles. Blink period: 2·BLINK_DIV cycles.
- At most one anode is low in any cycle. an never goes directly from one low digit to another without an all-high cycle in between.
- Simultaneous refresh wrap and blink wrap: both take effect at the same edge. The next output uses the new idx and the new phase.

## Test plan
- Reset values, REFRESH_DIV=4:
  - Stimulus: hold rst for 3 cycles, then release.
  - Required: an=1111, seg=1111111, dp=1 during reset and on edge 1. an=1110 on edge 2.
- Scan order and guard, REFRESH_DIV=4, digits 3/2/1/0 = 1,2,3,4:
  - Required an sequence, repeating: 1111, 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3.
  - Required seg per slot: 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
- Decode sweep: drive digit0 with 0..15, each held for one frame.
  - Required: seg matches the decode table; values 10–15 give 1111111 while an=1110.
- Decimal point: dp_mask=0100.
  - Required: dp=0 only while an=1011; dp=1 in all other cycles, including guard cycles.
- Blink, BLINK_DIV=8, REFRESH_DIV=4, blink_mask=0001, all digits=8:
  - Required: digit 0 shows seg=0000000 during phase 0 and stays dark (an=1111 in its slot) during phase 1. Digits 1–3 are unaffected.
- Reset mid-scan: assert rst for one cycle while an=1011.
  - Required: guard value at the next edge; scan restarts with digit 0 two edges after rst falls.
